bt_uart_rx: RTL and testbench

Parametrised UART receive front-end for the Bluetooth module link: oversamples the serial `rx` line, assembles LSB-first frames of configurable width, and validates start, stop and (optionally) parity. Each good frame produces a one-cycle `valid` pulse. From good frames it also holds the decoded `choice`/`dir` command fields that the game-control logic consumes. Bad frames are reported on error pulses and never disturb the held command.

---
 rtl/bt_uart_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bt_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bt_uart_rx.sv
// -----------------------------------------------------------------------------
// bt_uart_rx
// UART receive front-end for the Bluetooth module link. The raw rx line is
// synchronised, a falling edge starts a frame, and every bit is sampled in the
// middle of its bit period. Frames are start + DATA_W data bits (LSB first)
// + optional parity + stop. A good frame updates data/choice/dir and pulses
// valid; a bad frame pulses frame_err and/or parity_err and leaves the held
// outputs alone.
//
// Optional feature macro: BT_RX_PARITY_EN
//   defined   : a parity bit follows the data bits; PARITY_ODD selects sense
//   undefined : no parity bit; parity_err is tied to 0
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit period (>= 4)
//   DATA_W       : data bits per frame (>= 8)
//   PARITY_ODD   : 0 = even parity, 1 = odd parity (parity builds only)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last good frame, LSB = first received bit
//   valid      out  one-cycle pulse when data updates
//   frame_err  out  one-cycle pulse when the stop bit samples 0
//   parity_err out  one-cycle pulse on parity mismatch
//   busy       out  high while a frame is being received
//   choice     out  data[7:4] of the last good frame
//   dir        out  {data[3], data[0]} of the last good frame
// -----------------------------------------------------------------------------
module bt_uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_W       = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy,
    output logic [3:0]        choice,
    output logic [1:0]        dir
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

`ifdef BT_RX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    // Expected parity bit for a data word: XOR of all bits, inverted for odd.
    function automatic logic parity_bit(input logic [DATA_W-1:0] v, input logic odd);
        return (^v) ^ odd;
    endfunction
`else
    // Parity sense is irrelevant without a parity bit.
    logic unused_parity_odd_s;
    assign unused_parity_odd_s = (PARITY_ODD != 0);
`endif

    // Synchroniser and history flops; reset high so an idle line is not an edge.
    logic sync1_q, sync2_q, hist_q;
    logic start_edge_s;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [3:0]         choice_q, choice_d;
    logic [1:0]         dir_q, dir_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic               bit_end_s;
`ifdef BT_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_err_q, parity_err_d;
`endif

    assign start_edge_s = hist_q & ~sync2_q;
    assign bit_end_s    = (cnt_q == FULL_CNT);

    // Input synchroniser plus history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Receive FSM: next state, counters, shift register and result outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        choice_d    = choice_q;
        dir_d       = dir_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef BT_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_edge_s) begin
                    state_d = START;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef BT_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // Half a bit in: a high line means the edge was a glitch.
                if (cnt_q == HALF_CNT) begin
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = {CNT_W{1'b0}};
                        idx_d   = {IDX_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {sync2_q, shift_q[DATA_W-1:1]};
                    if (idx_q == LAST_IDX) begin
                        idx_d = {IDX_W{1'b0}};
`ifdef BT_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BT_RX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    cnt_d     = {CNT_W{1'b0}};
                    par_bad_d = (sync2_q != parity_bit(shift_q, ODD_BIT));
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Return to IDLE at mid-stop so a back-to-back start edge is seen.
                if (bit_end_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = IDLE;
`ifdef BT_RX_PARITY_EN
                    if (sync2_q && !par_bad_q) begin
`else
                    if (sync2_q) begin
`endif
                        data_d   = shift_q;
                        choice_d = shift_q[7:4];
                        dir_d    = {shift_q[3], shift_q[0]};
                        valid_d  = 1'b1;
                    end else begin
                        frame_err_d = ~sync2_q;
`ifdef BT_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            shift_q     <= {DATA_W{1'b0}};
            data_q      <= {DATA_W{1'b0}};
            choice_q    <= 4'h0;
            dir_q       <= 2'b00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BT_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            choice_q    <= choice_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef BT_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign choice    = choice_q;
    assign dir       = dir_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef BT_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_bt_uart_rx
// Directed bench for bt_uart_rx with CLKS_PER_BIT = 16, DATA_W = 8. Stimulus
// pushes the hand-computed expected result of each frame into a queue; a
// monitor pops one entry for every result pulse and compares flags and held
// outputs. Parity scenarios are compiled only with BT_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_bt_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic [2:0] flags;   // {valid, frame_err, parity_err}
        logic [7:0] data;
        logic [3:0] choice;
        logic [1:0] dir;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    logic [3:0] choice;
    logic [1:0] dir;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    bt_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy),
        .choice    (choice),
        .dir       (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_result(input logic [2:0] flags, input logic [7:0] d,
                                 input logic [3:0] c, input logic [1:0] r);
        exp_t e;
        e.flags  = flags;
        e.data   = d;
        e.choice = c;
        e.dir    = r;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef BT_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    // Monitor: every result pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst && (valid || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, valid, frame_err, parity_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("flags",  {29'd0, valid, frame_err, parity_err}, {29'd0, e.flags});
                check("data",   {24'd0, data},   {24'd0, e.data});
                check("choice", {28'd0, choice}, {28'd0, e.choice});
                check("dir",    {30'd0, dir},    {30'd0, e.dir});
                check("busy_at_pulse", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        bit seen_busy;
        rx  = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_choice_dir", {26'd0, choice, dir}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Good frame 0xA5.
        expect_result(3'b100, 8'hA5, 4'hA, 2'b01);
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("busy_after_a5", {31'd0, busy}, 32'd0);

        // Glitch: low for 4 cycles.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("glitch_busy_pulse", {31'd0, seen_busy}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_data_hold", {24'd0, data}, 32'hA5);

        // Framing error on 0x3C; held outputs stay at 0xA5.
        expect_result(3'b010, 8'hA5, 4'hA, 2'b01);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(posedge clk);

        // Back-to-back frames.
        expect_result(3'b100, 8'h12, 4'h1, 2'b00);
        expect_result(3'b100, 8'h34, 4'h3, 2'b00);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        repeat (20) @(posedge clk);

`ifdef BT_RX_PARITY_EN
        // Even parity: 0x01 needs parity bit 1.
        expect_result(3'b001, 8'h34, 4'h3, 2'b00);
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        expect_result(3'b100, 8'h01, 4'h0, 2'b01);
        send_frame(8'h01, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
`endif

        // Reset during the 4th data bit of 0xFF.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_data", {24'd0, data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_choice_dir", {26'd0, choice, dir}, 32'd0);
        check("midrst_pulses", {29'd0, valid, frame_err, parity_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        expect_result(3'b100, 8'h5A, 4'h5, 2'b10);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("busy_end", {31'd0, busy}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
